// File: rtl/imem_prog_pkg.sv
// Shared op codes, FSM encoding and memory geometry for the imem port-B controller.
package imem_prog_pkg;
  localparam int IMEM_ADDR_BITS = 13;
  localparam int IMEM_BYTES     = 1 << IMEM_ADDR_BITS;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'd0,
    OP_READ     = 2'd1,
    OP_CLEAR    = 2'd2,
    OP_CHECKSUM = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR, ST_RD, ST_CLR, ST_SUM, ST_DRAIN, ST_RESP
  } state_e;
endpackage

// File: rtl/imem_prog_controller_rd_latency_pipe.sv
// Valid shift register that tags RAM read data returning STAGES cycles after the address.
module rd_latency_pipe #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_valid,
  output logic out_valid,
  output logic empty
);
  logic [STAGES-1:0] sr;
  logic [STAGES:0]   vld_pipe;

  assign vld_pipe  = {sr, in_valid};
  assign out_valid = vld_pipe[STAGES];
  assign empty     = ~|sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sr <= '0;
    else          sr <= vld_pipe[STAGES-1:0];
  end
endmodule

// File: rtl/imem_prog_controller.sv
// Monitor-side sequencer for imem port B: write, read, clear-range and checksum-range commands.
module imem_prog_controller
  import imem_prog_pkg::*;
#(
  parameter int ADDR_BITS  = IMEM_ADDR_BITS,
  parameter int RD_LATENCY = 2,
  parameter int LEN_BITS   = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                hold_req,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [31:0]         cmd_addr,
  input  logic [31:0]         cmd_wdata,
  input  logic [LEN_BITS-1:0] cmd_len,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [31:0]         resp_data,
  output logic                resp_err,
  output logic                prg_we,
  output logic [31:0]         prg_addr,
  output logic [31:0]         prg_wd,
  input  logic [31:0]         prg_rd,
  output logic                cpu_hold
);
  localparam int             EW      = ADDR_BITS + LEN_BITS + 3;
  localparam logic [EW-1:0]  MEM_END = EW'(1) << ADDR_BITS;

  state_e               state;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LEN_BITS-1:0]  cnt_q;
  logic [31:0]          acc_q;
  logic                 rd_issue;
  logic                 pipe_out, pipe_empty;
  logic                 accept, is_range, cmd_err;
  logic [EW-1:0]        end_addr;

  assign cmd_ready = (state == ST_IDLE) && reset_n;
  assign cpu_hold  = hold_req | (state != ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;

  // Range end is computed wide enough that addr + 4*len can never wrap.
  assign end_addr = EW'(cmd_addr[ADDR_BITS-1:0]) + EW'({cmd_len, 2'b00});
  assign is_range = (cmd_op == OP_CLEAR) || (cmd_op == OP_CHECKSUM);
  assign cmd_err  = (|cmd_addr[1:0]) || (|cmd_addr[31:ADDR_BITS]) ||
                    (is_range && (end_addr > MEM_END));

  rd_latency_pipe #(.STAGES(RD_LATENCY)) u_rd_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (rd_issue),
    .out_valid (pipe_out),
    .empty     (pipe_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      rd_issue   <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      prg_we     <= 1'b0;
      prg_addr   <= '0;
      prg_wd     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          addr_q <= cmd_addr[ADDR_BITS-1:0] + ADDR_BITS'(4);
          cnt_q  <= cmd_len - LEN_BITS'(1);
          acc_q  <= '0;
          if (cmd_err || (is_range && cmd_len == '0)) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= cmd_err;
            resp_data  <= '0;
          end else begin
            prg_addr <= 32'(cmd_addr[ADDR_BITS-1:0]);
            case (op_e'(cmd_op))
              OP_WRITE: begin
                prg_we <= 1'b1;
                prg_wd <= cmd_wdata;
                state  <= ST_WR;
              end
              OP_READ: begin
                rd_issue <= 1'b1;
                state    <= ST_RD;
              end
              OP_CLEAR: begin
                prg_we <= 1'b1;
                prg_wd <= '0;
                state  <= ST_CLR;
              end
              default: begin
                rd_issue <= 1'b1;
                state    <= ST_SUM;
              end
            endcase
          end
        end
        ST_WR: begin
          prg_we     <= 1'b0;
          prg_addr   <= '0;
          prg_wd     <= '0;
          resp_valid <= 1'b1;
          resp_data  <= '0;
          state      <= ST_RESP;
        end
        ST_RD: begin
          prg_addr <= '0;
          rd_issue <= 1'b0;
          if (pipe_out) begin
            resp_data  <= prg_rd;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_CLR: begin
          if (cnt_q != '0) begin
            prg_addr <= 32'(addr_q);
            addr_q   <= addr_q + ADDR_BITS'(4);
            cnt_q    <= cnt_q - LEN_BITS'(1);
          end else begin
            prg_we     <= 1'b0;
            prg_addr   <= '0;
            resp_valid <= 1'b1;
            resp_data  <= '0;
            state      <= ST_RESP;
          end
        end
        ST_SUM: begin
          if (pipe_out) acc_q <= acc_q + prg_rd;
          if (cnt_q != '0) begin
            prg_addr <= 32'(addr_q);
            addr_q   <= addr_q + ADDR_BITS'(4);
            cnt_q    <= cnt_q - LEN_BITS'(1);
          end else begin
            prg_addr <= '0;
            rd_issue <= 1'b0;
            state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Empty means the last tagged word was already folded into acc_q.
          if (pipe_out) acc_q <= acc_q + prg_rd;
          if (pipe_empty) begin
            resp_data  <= acc_q;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_data  <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_prog_controller.sv
// Bench for imem_prog_controller: latency-2 RAM model plus a word-array reference model.
module tb_imem_prog_controller;
  import imem_prog_pkg::*;

  localparam int MEMB = 8192;
  localparam int NW   = MEMB / 4;

  logic        clk = 1'b0, reset_n = 1'b0, hold_req = 1'b0;
  logic        cmd_valid = 1'b0, resp_ready = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [11:0] cmd_len = '0;
  logic        cmd_ready, resp_valid, resp_err, prg_we, cpu_hold;
  logic [31:0] resp_data, prg_addr, prg_wd, prg_rd, rd_p1;

  logic [31:0] ram     [NW];
  logic [31:0] ref_mem [NW];
  logic        loaded = 1'b0;

  int n_pass = 0, n_total = 0;
  int cyc = 0, acc_cyc = 0, we_cnt = 0;
  logic [63:0] we_q[$];
  logic [31:0] rd_q[$];
  int          rd_cyc[$];

  imem_prog_controller dut (
    .clk(clk), .reset_n(reset_n), .hold_req(hold_req),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .prg_we(prg_we), .prg_addr(prg_addr), .prg_wd(prg_wd),
    .prg_rd(prg_rd), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM port B: registered address plus one output register = 2-cycle read latency.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < NW; i++) ram[i] <= 32'(i) * 32'h9E37_79B1;
      loaded <= 1'b1;
    end else if (prg_we) ram[prg_addr[12:2]] <= prg_wd;
    rd_p1  <= ram[prg_addr[12:2]];
    prg_rd <= rd_p1;
  end

  always @(negedge clk) begin
    if (prg_we) begin
      we_cnt++;
      we_q.push_back({prg_addr, prg_wd});
    end else if (prg_addr != 0) begin
      rd_q.push_back(prg_addr);
      rd_cyc.push_back(cyc);
    end
  end

  task automatic model(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [11:0] len, output logic [31:0] d, output logic e, output int nwe);
    longint a, endb;
    int w;
    a = longint'(addr);
    endb = a + 4 * longint'(len);
    e = (a % 4 != 0) || (a >= MEMB) || (op >= 2 && endb > MEMB);
    d = '0;
    nwe = 0;
    w = int'(a / 4);
    if (!e) begin
      case (op)
        2'd0: begin ref_mem[w] = wdata; nwe = 1; end
        2'd1: d = ref_mem[w];
        2'd2: begin for (int i = 0; i < int'(len); i++) ref_mem[w+i] = '0; nwe = int'(len); end
        default: for (int i = 0; i < int'(len); i++) d = d + ref_mem[w+i];
      endcase
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [11:0] len, input int bp, output logic [31:0] d, output logic e,
                        output int lat, output bit hold_ok, output bit stable_ok, output bit idle_ok);
    int guard;
    d = '0; e = 1'b0; lat = -1; hold_ok = 1; stable_ok = 1; idle_ok = 1;
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_len = len; cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!cmd_ready) begin
      n_total++;
      $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    acc_cyc = cyc;
    lat = 1;
    while (!resp_valid && lat < 300) begin
      if (!cpu_hold) hold_ok = 0;
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin
      n_total++;
      $display("FAIL resp_timeout: resp_valid=%b required 1", resp_valid);
      lat = -1;
      return;
    end
    d = resp_data;
    e = resp_err;
    for (int i = 0; i < bp; i++) begin
      if (!cpu_hold) hold_ok = 0;
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== d || resp_err !== e ||
          cmd_ready !== 1'b0 || cpu_hold !== 1'b1) stable_ok = 0;
    end
    if (!cpu_hold) hold_ok = 0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    if (cmd_ready !== 1'b1 || cpu_hold !== 1'b0 || resp_valid !== 1'b0) idle_ok = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({cmd_ready, prg_we, resp_valid, cpu_hold} !== 4'b0)
      $display("FAIL reset_outputs: ready/we/rvalid/hold=%b required 0000", {cmd_ready, prg_we, resp_valid, cpu_hold});
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (cmd_ready !== 1'b1 || prg_addr !== 32'h0 || cpu_hold !== 1'b0)
      $display("FAIL reset_release: ready=%b addr=%h hold=%b required 1 0 0", cmd_ready, prg_addr, cpu_hold);
    else n_pass++;
  endtask

  task automatic test_hold_req();
    @(negedge clk); hold_req = 1'b1; #1;
    n_total++;
    if (cpu_hold !== 1'b1 || cmd_ready !== 1'b1)
      $display("FAIL hold_req_idle: hold=%b ready=%b required 1 1", cpu_hold, cmd_ready);
    else n_pass++;
    @(negedge clk); hold_req = 1'b0; #1;
    n_total++;
    if (cpu_hold !== 1'b0) $display("FAIL hold_req_release: hold=%b required 0", cpu_hold);
    else n_pass++;
  endtask

  task automatic test_write();
    logic [31:0] d, md; logic e, me; int lat, nwe, wb, qb; bit h, s, i;
    wb = we_cnt; qb = we_q.size();
    do_cmd(2'd0, 32'h10, 32'hDEAD_BEEF, 12'd0, 0, d, e, lat, h, s, i);
    model(2'd0, 32'h10, 32'hDEAD_BEEF, 12'd0, md, me, nwe);
    n_total++;
    if (lat !== 2 || e !== me || d !== md)
      $display("FAIL write_resp: lat=%0d err=%b data=%h required 2 %b %h", lat, e, d, me, md);
    else n_pass++;
    n_total++;
    if (we_cnt - wb !== 1 || we_q.size() <= qb || we_q[qb] !== {32'h10, 32'hDEAD_BEEF})
      $display("FAIL write_port: we_cycles=%0d required 1", we_cnt - wb);
    else n_pass++;
    n_total++;
    if (!h || !i) $display("FAIL write_hold: hold_ok=%0d idle_ok=%0d required 1 1", h, i);
    else n_pass++;
  endtask

  task automatic test_read();
    logic [31:0] d, md; logic e, me; int lat, nwe; bit h, s, i;
    do_cmd(2'd1, 32'h10, 32'h0, 12'd0, 0, d, e, lat, h, s, i);
    model(2'd1, 32'h10, 32'h0, 12'd0, md, me, nwe);
    n_total++;
    if (lat !== 4 || e !== me || d !== md)
      $display("FAIL read_resp: lat=%0d err=%b data=%h required 4 %b %h", lat, e, d, me, md);
    else n_pass++;
  endtask

  task automatic test_clear();
    logic [31:0] d, md; logic e, me; int lat, nwe, wb, qb; bit h, s, i, ok;
    wb = we_cnt; qb = we_q.size();
    do_cmd(2'd2, 32'h100, 32'h0, 12'd4, 0, d, e, lat, h, s, i);
    model(2'd2, 32'h100, 32'h0, 12'd4, md, me, nwe);
    ok = (we_cnt - wb == nwe) && (we_q.size() - qb == nwe);
    if (ok) for (int k = 0; k < nwe; k++)
      if (we_q[qb+k] !== {32'h100 + 32'(4*k), 32'h0}) ok = 0;
    n_total++;
    if (!ok) $display("FAIL clear_writes: we_cycles=%0d required %0d at 0x100.. step 4 wd 0", we_cnt - wb, nwe);
    else n_pass++;
    n_total++;
    if (e !== me || d !== md || !h) $display("FAIL clear_resp: err=%b data=%h hold=%0d required %b %h 1", e, d, h, me, md);
    else n_pass++;
    do_cmd(2'd1, 32'h108, 32'h0, 12'd0, 0, d, e, lat, h, s, i);
    model(2'd1, 32'h108, 32'h0, 12'd0, md, me, nwe);
    n_total++;
    if (d !== md || e !== me) $display("FAIL clear_readback: data=%h err=%b required %h %b", d, e, md, me);
    else n_pass++;
  endtask

  task automatic test_checksum();
    logic [31:0] d, md; logic e, me; int lat, nwe, rb; bit h, s, i;
    logic [31:0] vals [3];
    vals[0] = 32'h1; vals[1] = 32'h2; vals[2] = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      do_cmd(2'd0, 32'(4*k), vals[k], 12'd0, 0, d, e, lat, h, s, i);
      model(2'd0, 32'(4*k), vals[k], 12'd0, md, me, nwe);
    end
    rb = rd_q.size();
    do_cmd(2'd3, 32'h0, 32'h0, 12'd3, 0, d, e, lat, h, s, i);
    model(2'd3, 32'h0, 32'h0, 12'd3, md, me, nwe);
    n_total++;
    if (d !== md || e !== me) $display("FAIL checksum_value: data=%h err=%b required %h %b", d, e, md, me);
    else n_pass++;
    n_total++;
    if (rd_q.size() - rb !== 2 || rd_q[rb] !== 32'h4 || rd_q[rb+1] !== 32'h8 ||
        rd_cyc[rb] - acc_cyc !== 1 || rd_cyc[rb+1] - acc_cyc !== 2)
      $display("FAIL checksum_issue: nonzero_reads=%0d required 2 (0x4,0x8 on cycles 2,3)", rd_q.size() - rb);
    else n_pass++;
    rb = rd_q.size();
    do_cmd(2'd3, 32'h40, 32'h0, 12'd0, 0, d, e, lat, h, s, i);
    n_total++;
    if (lat !== 1 || d !== 32'h0 || e !== 1'b0 || rd_q.size() !== rb)
      $display("FAIL checksum_len0: lat=%0d data=%h err=%b reads=%0d required 1 0 0 0", lat, d, e, rd_q.size() - rb);
    else n_pass++;
  endtask

  task automatic test_errors();
    logic [31:0] d, md; logic e, me; int lat, nwe, wb; bit h, s, i;
    logic [1:0]  ops   [4];
    logic [31:0] addrs [4];
    logic [11:0] lens  [4];
    ops[0] = 2'd1; addrs[0] = 32'h12;   lens[0] = 12'd0;
    ops[1] = 2'd0; addrs[1] = 32'h2000; lens[1] = 12'd0;
    ops[2] = 2'd2; addrs[2] = 32'h1FF8; lens[2] = 12'd3;
    ops[3] = 2'd2; addrs[3] = 32'h1FF8; lens[3] = 12'd2;
    for (int k = 0; k < 4; k++) begin
      wb = we_cnt;
      do_cmd(ops[k], addrs[k], 32'h1234_5678, lens[k], 0, d, e, lat, h, s, i);
      model(ops[k], addrs[k], 32'h1234_5678, lens[k], md, me, nwe);
      n_total++;
      if (e !== me || d !== md || we_cnt - wb !== nwe)
        $display("FAIL error_case%0d: err=%b data=%h we=%0d required %b %h %0d", k, e, d, we_cnt - wb, me, md, nwe);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [31:0] d, md; logic e, me; int lat, nwe; bit h, s, i;
    @(negedge clk);
    cmd_op = 2'd2; cmd_addr = 32'h200; cmd_len = 12'd8; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_total++;
    if (prg_we !== 1'b0 || cpu_hold !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL reset_mid_clear: we=%b hold=%b rvalid=%b required 0 0 0", prg_we, cpu_hold, resp_valid);
    else n_pass++;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (cmd_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL reset_mid_release: ready=%b rvalid=%b required 1 0", cmd_ready, resp_valid);
    else n_pass++;
    ref_mem[32'h200/4] = '0;
    ref_mem[32'h204/4] = '0;
    do_cmd(2'd1, 32'h204, 32'h0, 12'd0, 0, d, e, lat, h, s, i);
    model(2'd1, 32'h204, 32'h0, 12'd0, md, me, nwe);
    n_total++;
    if (d !== md) $display("FAIL reset_mid_word1: data=%h required %h", d, md);
    else n_pass++;
    do_cmd(2'd1, 32'h208, 32'h0, 12'd0, 0, d, e, lat, h, s, i);
    model(2'd1, 32'h208, 32'h0, 12'd0, md, me, nwe);
    n_total++;
    if (d !== md) $display("FAIL reset_mid_word2: data=%h required %h", d, md);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] d, md; logic e, me; int lat, nwe; bit h, s, i;
    do_cmd(2'd1, 32'h10, 32'h0, 12'd0, 5, d, e, lat, h, s, i);
    model(2'd1, 32'h10, 32'h0, 12'd0, md, me, nwe);
    n_total++;
    if (!s || !h || !i || d !== md)
      $display("FAIL backpressure: stable=%0d hold=%0d idle=%0d data=%h required 1 1 1 %h", s, h, i, d, md);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] d, md, addr; logic e, me; int lat, nwe, wb, kind, bp; bit h, s, i;
    logic [1:0] op; logic [11:0] len;
    for (int n = 0; n < 60; n++) begin
      op   = 2'($urandom_range(0, 3));
      len  = 12'($urandom_range(0, 8));
      kind = $urandom_range(0, 9);
      addr = 32'($urandom_range(0, 255)) * 4;
      if (kind == 0) addr = addr | 32'($urandom_range(1, 3));
      else if (kind == 1) addr = 32'h2000 - 32'($urandom_range(0, 8)) * 4;
      else if (kind == 2) addr = 32'h2000 + 32'($urandom_range(0, 255)) * 4;
      bp = $urandom_range(0, 2);
      wb = we_cnt;
      do_cmd(op, addr, $urandom, len, bp, d, e, lat, h, s, i);
      model(op, addr, cmd_wdata, len, md, me, nwe);
      n_total++;
      if (d !== md || e !== me || we_cnt - wb !== nwe || !h || !s || !i)
        $display("FAIL random%0d op=%0d addr=%h len=%0d: data=%h err=%b we=%0d hold=%0d stable=%0d required %h %b %0d 1 1",
                 n, op, addr, len, d, e, we_cnt - wb, h, s, md, me, nwe);
      else n_pass++;
      if (!e && op == 2'd0) begin
        n_total++;
        if (lat !== 2) $display("FAIL random%0d write_latency: %0d required 2", n, lat); else n_pass++;
      end else if (!e && op == 2'd1) begin
        n_total++;
        if (lat !== 4) $display("FAIL random%0d read_latency: %0d required 4", n, lat); else n_pass++;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NW; k++) ref_mem[k] = 32'(k) * 32'h9E37_79B1;
    test_reset();
    test_hold_req();
    test_write();
    test_read();
    test_clear();
    test_checksum();
    test_errors();
    test_reset_mid_clear();
    test_backpressure();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
